// File: rtl/adj_pkg.sv
// Shared types and constants for the adjacency fetch controller.
package adj_pkg;

  localparam int unsigned ADJ_NODE_IDX_WIDTH  = 10;
  localparam int unsigned ADJ_COUNTER_WIDTH   = 5;
  localparam int unsigned ADJ_EDGE_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HDR    = 2'd1,
    S_LOOKUP = 2'd2,
    S_STREAM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CFG_NODE = 2'd0,
    CFG_EDGE = 2'd1,
    CFG_HDR  = 2'd2
  } cfg_sel_e;

  localparam logic [1:0] HDR_START = 2'd0;
  localparam logic [1:0] HDR_MID0  = 2'd1;
  localparam logic [1:0] HDR_MID1  = 2'd2;
  localparam logic [1:0] HDR_END   = 2'd3;

  // Node table entry at the default widths: {base, degree}.
  typedef struct packed {
    logic [ADJ_EDGE_ADDR_WIDTH-1:0] base;
    logic [ADJ_COUNTER_WIDTH-1:0]   degree;
  } node_entry_t;

endpackage

// File: rtl/adj_sync_ram.sv
// Single-port-write, single synchronous-read RAM; contents are not reset.
module adj_sync_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port plus registered read, one cycle of latency.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adj_fetch_ctrl.sv
// Adjacency fetch controller: header emission and per-node successor streaming.
module adj_fetch_ctrl
  import adj_pkg::*;
#(
  parameter int unsigned NODE_IDX_WIDTH  = ADJ_NODE_IDX_WIDTH,
  parameter int unsigned COUNTER_WIDTH   = ADJ_COUNTER_WIDTH,
  parameter int unsigned EDGE_ADDR_WIDTH = ADJ_EDGE_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [((NODE_IDX_WIDTH > EDGE_ADDR_WIDTH) ? NODE_IDX_WIDTH : EDGE_ADDR_WIDTH)-1:0] cfg_addr,
  input  logic [EDGE_ADDR_WIDTH+COUNTER_WIDTH-1:0] cfg_wdata,
  output logic                       cfg_err,
  input  logic                       start_run,
  input  logic                       part_sel,
  input  logic                       req_valid,
  input  logic [NODE_IDX_WIDTH-1:0]  req_node_idx,
  output logic                       req_ready,
  output logic                       rsp_valid,
  output logic [NODE_IDX_WIDTH-1:0]  rsp_node_idx,
  output logic [COUNTER_WIDTH-1:0]   rsp_counter,
  output logic                       rsp_hdr,
  output logic                       rsp_empty,
  output logic                       busy
);

  localparam int unsigned ENTRY_W = EDGE_ADDR_WIDTH + COUNTER_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE  = 1;
  localparam logic [EDGE_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_e                      state_q;
  logic                        cfg_err_q;
  logic                        rsp_valid_q;
  logic                        rsp_hdr_q;
  logic                        rsp_empty_q;
  logic                        from_ram_q;
  logic [NODE_IDX_WIDTH-1:0]   node_q;
  logic [COUNTER_WIDTH-1:0]    cnt_q;
  logic [EDGE_ADDR_WIDTH-1:0]  addr_q;
  logic                        part_q;
  logic [1:0]                  pos_q;
  logic [NODE_IDX_WIDTH-1:0]   hdr_q [4];

  logic                        idle;
  logic                        node_we, edge_we, hdr_we;
  logic [ENTRY_W-1:0]          node_rdata;
  logic [NODE_IDX_WIDTH-1:0]   edge_rdata;
  logic [EDGE_ADDR_WIDTH-1:0]  node_base;
  logic [COUNTER_WIDTH-1:0]    node_deg;
  logic [EDGE_ADDR_WIDTH-1:0]  edge_raddr_d;
  logic [1:0]                  pos_d;

  assign idle      = (state_q == S_IDLE);
  assign node_we   = cfg_we && idle && (cfg_sel == CFG_NODE);
  assign edge_we   = cfg_we && idle && (cfg_sel == CFG_EDGE);
  assign hdr_we    = cfg_we && idle && (cfg_sel == CFG_HDR);
  assign node_base = node_rdata[COUNTER_WIDTH +: EDGE_ADDR_WIDTH];
  assign node_deg  = node_rdata[COUNTER_WIDTH-1:0];
  assign pos_d     = pos_q + 2'd1;
  // First edge is read straight from the table entry; later ones from the walking pointer.
  assign edge_raddr_d = (state_q == S_LOOKUP) ? node_base : addr_q;

  adj_sync_ram #(.WIDTH(ENTRY_W), .ADDR_WIDTH(NODE_IDX_WIDTH)) u_node_tbl (
    .clk_i   (clk),
    .we_i    (node_we),
    .waddr_i (cfg_addr[NODE_IDX_WIDTH-1:0]),
    .wdata_i (cfg_wdata),
    .raddr_i (req_node_idx),
    .rdata_o (node_rdata)
  );

  adj_sync_ram #(.WIDTH(NODE_IDX_WIDTH), .ADDR_WIDTH(EDGE_ADDR_WIDTH)) u_edge_list (
    .clk_i   (clk),
    .we_i    (edge_we),
    .waddr_i (cfg_addr[EDGE_ADDR_WIDTH-1:0]),
    .wdata_i (cfg_wdata[NODE_IDX_WIDTH-1:0]),
    .raddr_i (edge_raddr_d),
    .rdata_o (edge_rdata)
  );

  // Header node registers, written from the config port while idle.
  always_ff @(posedge clk) begin
    if (hdr_we) hdr_q[cfg_addr[1:0]] <= cfg_wdata[NODE_IDX_WIDTH-1:0];
  end

  // Control FSM with registered response fields; words default to cleared each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hdr_q   <= 1'b0;
      rsp_empty_q <= 1'b0;
      from_ram_q  <= 1'b0;
      node_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      part_q      <= 1'b0;
      pos_q       <= '0;
    end else begin
      if (cfg_we && !idle) cfg_err_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hdr_q   <= 1'b0;
      rsp_empty_q <= 1'b0;
      from_ram_q  <= 1'b0;
      node_q      <= '0;
      cnt_q       <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_run) begin
            state_q     <= S_HDR;
            part_q      <= part_sel;
            pos_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_hdr_q   <= 1'b1;
            node_q      <= hdr_q[HDR_START];
          end else if (req_valid) begin
            state_q <= S_LOOKUP;
          end
        end
        S_HDR: begin
          if (pos_q == (part_q ? 2'd3 : 2'd1)) begin
            state_q <= S_IDLE;
          end else begin
            pos_q       <= pos_d;
            rsp_valid_q <= 1'b1;
            rsp_hdr_q   <= 1'b1;
            // Short sequence jumps straight from start to end.
            node_q      <= hdr_q[part_q ? pos_d : HDR_END];
          end
        end
        S_LOOKUP: begin
          state_q     <= S_STREAM;
          rsp_valid_q <= 1'b1;
          if (node_deg == '0) begin
            rsp_empty_q <= 1'b1;
          end else begin
            from_ram_q <= 1'b1;
            cnt_q      <= node_deg;
            addr_q     <= node_base + ADDR_ONE;
          end
        end
        S_STREAM: begin
          if (rsp_empty_q || cnt_q == CNT_ONE) begin
            state_q <= S_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
            from_ram_q  <= 1'b1;
            cnt_q       <= cnt_q - CNT_ONE;
            addr_q      <= addr_q + ADDR_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Edge words come from the RAM's own output register; from_ram_q resets low so
  // the node index still reads 0 asynchronously during reset.
  assign rsp_node_idx = from_ram_q ? edge_rdata : node_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_counter  = cnt_q;
  assign rsp_hdr      = rsp_hdr_q;
  assign rsp_empty    = rsp_empty_q;
  assign cfg_err      = cfg_err_q;
  assign req_ready    = idle;
  assign busy         = !idle;

endmodule

// File: tb/tb_adj_fetch_ctrl.sv
// Directed self-checking bench for adj_fetch_ctrl.
module tb_adj_fetch_ctrl;
  import adj_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [11:0] cfg_addr;
  logic [16:0] cfg_wdata;
  logic        cfg_err;
  logic        start_run;
  logic        part_sel;
  logic        req_valid;
  logic [9:0]  req_node_idx;
  logic        req_ready;
  logic        rsp_valid;
  logic [9:0]  rsp_node_idx;
  logic [4:0]  rsp_counter;
  logic        rsp_hdr;
  logic        rsp_empty;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  adj_fetch_ctrl #(
    .NODE_IDX_WIDTH  (10),
    .COUNTER_WIDTH   (5),
    .EDGE_ADDR_WIDTH (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_err      (cfg_err),
    .start_run    (start_run),
    .part_sel     (part_sel),
    .req_valid    (req_valid),
    .req_node_idx (req_node_idx),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_node_idx (rsp_node_idx),
    .rsp_counter  (rsp_counter),
    .rsp_hdr      (rsp_hdr),
    .rsp_empty    (rsp_empty),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks one cycle's response fields plus handshake.
  task automatic chk_word(input string tag, input logic v, input int idx, input int cnt,
                          input logic h, input logic e, input logic rdy);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".idx"},   32'(rsp_node_idx), 32'(idx));
    chk({tag, ".cnt"},   32'(rsp_counter), 32'(cnt));
    chk({tag, ".hdr"},   32'(rsp_hdr), 32'(h));
    chk({tag, ".empty"}, 32'(rsp_empty), 32'(e));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".busy"},  32'(busy), 32'(!rdy));
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = 12'(addr);
    cfg_wdata = 17'(data);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic node_write(input int idx, input int base, input int deg);
    node_entry_t e;
    e.base   = 12'(base);
    e.degree = 5'(deg);
    cfg_write(2'd0, idx, 32'(e));
  endtask

  task automatic request(input int idx);
    req_valid    = 1'b1;
    req_node_idx = 10'(idx);
    tick();
    req_valid    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
    start_run = 1'b0; part_sel = 1'b0; req_valid = 1'b0; req_node_idx = '0;
    #2;
    chk_word("reset", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("reset.cfg_err", 32'(cfg_err), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    node_write(5, 100, 3);
    node_write(8, 0, 0);
    node_write(6, 4095, 2);
    cfg_write(2'd1, 100, 7);
    cfg_write(2'd1, 101, 9);
    cfg_write(2'd1, 102, 11);
    cfg_write(2'd1, 4095, 20);
    cfg_write(2'd1, 0, 21);
    cfg_write(2'd2, 0, 1);
    cfg_write(2'd2, 1, 2);
    cfg_write(2'd2, 2, 3);
    cfg_write(2'd2, 3, 4);
    chk("cfg_err_idle_writes", 32'(cfg_err), 0);

    // Node 5, degree 3.
    request(5);
    chk_word("n5.lookup", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n5.w1", 1'b1, 7, 3, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n5.w2", 1'b1, 9, 2, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n5.w3", 1'b1, 11, 1, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n5.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Node 8, degree 0.
    request(8);
    tick(); chk_word("n8.empty", 1'b1, 0, 0, 1'b0, 1'b1, 1'b0);
    tick(); chk_word("n8.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Long header; part_sel flipped afterwards must not matter.
    start_run = 1'b1; part_sel = 1'b1;
    tick();
    start_run = 1'b0; part_sel = 1'b0;
    chk_word("h4.w1", 1'b1, 1, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h4.w2", 1'b1, 2, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h4.w3", 1'b1, 3, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h4.w4", 1'b1, 4, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h4.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Short header with a simultaneous request: start_run wins.
    start_run = 1'b1; part_sel = 1'b0; req_valid = 1'b1; req_node_idx = 10'd5;
    tick();
    start_run = 1'b0; req_valid = 1'b0;
    chk_word("h2.w1", 1'b1, 1, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h2.w2", 1'b1, 4, 0, 1'b1, 1'b0, 1'b0);
    tick(); chk_word("h2.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Wrap-around at the top of the edge list.
    request(6);
    tick(); chk_word("n6.w1", 1'b1, 20, 2, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n6.w2", 1'b1, 21, 1, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("n6.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Config write while streaming is dropped and flags cfg_err.
    request(5);
    tick();
    cfg_write(2'd1, 101, 99);
    chk_word("busyw.w2", 1'b1, 9, 2, 1'b0, 1'b0, 1'b0);
    chk("busyw.cfg_err", 32'(cfg_err), 1);
    tick(); chk_word("busyw.w3", 1'b1, 11, 1, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("busyw.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    request(5);
    tick(); tick(); chk_word("unchanged.w2", 1'b1, 9, 2, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    cfg_write(2'd1, 101, 55);
    chk("idlew.cfg_err_sticky", 32'(cfg_err), 1);
    request(5);
    tick(); tick(); chk_word("idlew.w2", 1'b1, 55, 2, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("idlew.cfg_err_still", 32'(cfg_err), 1);

    // Reset during the second stream word.
    request(5);
    tick(); tick();
    chk_word("rst.w2", 1'b1, 55, 2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_word("rst.async", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("rst.cfg_err", 32'(cfg_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    request(6);
    tick(); chk_word("post.w1", 1'b1, 20, 2, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("post.w2", 1'b1, 21, 1, 1'b0, 1'b0, 1'b0);
    tick(); chk_word("post.done", 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
